// File: rtl/rtc_time_of_day.sv
// BCD hh:mm:ss time-of-day counter with prescaler, 12/24 h display and day count.
// Optional alarm comparator is built only when RTC_ALARM_EN is defined.
module rtc_time_of_day #(
    parameter int unsigned DIV   = 50_000_000,
    parameter int unsigned DAY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode12,
    input  logic             set_valid,
    input  logic [7:0]       set_hh,
    input  logic [7:0]       set_mm,
    input  logic [7:0]       set_ss,
    output logic             set_err,
    output logic [3:0]       hh_t,
    output logic [3:0]       hh_o,
    output logic [3:0]       mm_t,
    output logic [3:0]       mm_o,
    output logic [3:0]       ss_t,
    output logic [3:0]       ss_o,
    output logic             pm,
    output logic             sec_pulse,
    output logic             min_pulse,
    output logic             day_pulse,
    output logic [DAY_W-1:0] day_count,
    input  logic [7:0]       alarm_hh,
    input  logic [7:0]       alarm_mm,
    input  logic             alarm_arm,
    output logic             alarm_hit
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0]    pre_q, pre_d;
    logic [7:0]       h_q, h_d, m_q, m_d, s_q, s_d;
    logic [DAY_W-1:0] day_q, day_d;
    logic [7:0]       hdisp_q, hdisp_d;
    logic             pm_q, pm_d;
    logic             sec_q, sec_d, min_q, min_d, dayp_q, dayp_d;
    logic             err_q, err_d;

    logic tick, legal, load, step;
    logic s_wrap, m_wrap, h_wrap;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] to12(input logic [7:0] v);
        logic [4:0] hb;
        hb = 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
        if (hb == 5'd0) hb = 5'd12;
        else if (hb > 5'd12) hb = hb - 5'd12;
        if (hb >= 5'd10) return {4'd1, 4'(hb - 5'd10)};
        return {4'd0, 4'(hb)};
    endfunction

    always_comb begin
        tick  = en && (pre_q == LAST);
        // With every nibble <= 9, plain compares on the BCD bytes are numeric
        legal = (set_hh[7:4] <= 4'd9) && (set_hh[3:0] <= 4'd9) &&
                (set_mm[7:4] <= 4'd9) && (set_mm[3:0] <= 4'd9) &&
                (set_ss[7:4] <= 4'd9) && (set_ss[3:0] <= 4'd9) &&
                (set_hh <= 8'h23) && (set_mm <= 8'h59) && (set_ss <= 8'h59);
        load   = set_valid && legal;
        step   = tick && !load;
        s_wrap = (s_q == 8'h59);
        m_wrap = (m_q == 8'h59);
        h_wrap = (h_q == 8'h23);

        pre_d = pre_q;
        h_d   = h_q;
        m_d   = m_q;
        s_d   = s_q;
        day_d = day_q;

        if (load || tick) pre_d = '0;
        else if (en) pre_d = pre_q + 1'b1;

        if (load) begin
            h_d = set_hh;
            m_d = set_mm;
            s_d = set_ss;
        end else if (step) begin
            s_d = s_wrap ? 8'h00 : bcd_inc(s_q);
            if (s_wrap) m_d = m_wrap ? 8'h00 : bcd_inc(m_q);
            if (s_wrap && m_wrap) h_d = h_wrap ? 8'h00 : bcd_inc(h_q);
            if (s_wrap && m_wrap && h_wrap) day_d = day_q + 1'b1;
        end

        hdisp_d = mode12 ? to12(h_d) : h_d;
        pm_d    = (h_d >= 8'h12);
        sec_d   = step;
        min_d   = step && s_wrap;
        dayp_d  = step && s_wrap && m_wrap && h_wrap;
        err_d   = set_valid && !legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            h_q     <= 8'h00;
            m_q     <= 8'h00;
            s_q     <= 8'h00;
            day_q   <= '0;
            hdisp_q <= 8'h00;
            pm_q    <= 1'b0;
            sec_q   <= 1'b0;
            min_q   <= 1'b0;
            dayp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            day_q   <= day_d;
            hdisp_q <= hdisp_d;
            pm_q    <= pm_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            dayp_q  <= dayp_d;
            err_q   <= err_d;
        end
    end

    assign hh_t      = hdisp_q[7:4];
    assign hh_o      = hdisp_q[3:0];
    assign mm_t      = m_q[7:4];
    assign mm_o      = m_q[3:0];
    assign ss_t      = s_q[7:4];
    assign ss_o      = s_q[3:0];
    assign pm        = pm_q;
    assign sec_pulse = sec_q;
    assign min_pulse = min_q;
    assign day_pulse = dayp_q;
    assign day_count = day_q;
    assign set_err   = err_q;

`ifdef RTC_ALARM_EN
    logic alarm_q, alarm_d;

    // Only a counting step can fire; loads landing on the alarm time stay silent
    always_comb begin
        alarm_d = step && alarm_arm &&
                  (h_d == alarm_hh) && (m_d == alarm_mm) && (s_d == 8'h00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) alarm_q <= 1'b0;
        else     alarm_q <= alarm_d;
    end

    assign alarm_hit = alarm_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_hh, alarm_mm, alarm_arm};
    assign alarm_hit    = 1'b0;
`endif

endmodule
